multicycle_ctrl: RTL and testbench
==================================

Name: multicycle_ctrl

Overview:
- Multi-cycle sequencer for the MIPS core's shared-memory datapath.
- Supports the same instruction set as the single-cycle core: addu, subu, and, or, slt, nop, lw, sw, lui, ori, j, jal, jr, beq.
- A Moore FSM emits per-state datapath controls and stalls on a memory ready handshake.
- Bounded waits: a memory timeout or an illegal instruction parks the block in a sticky error state.

Parameters:
- WAIT_LIMIT, 15: maximum consecutive cycles spent waiting on mem_ready before entering ERR.
- WAIT_W, 4: width of the wait counter; must satisfy 2^WAIT_W > WAIT_LIMIT.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- opcode  in  6  IR[31:26], valid from DECODE onward.
- funct  in  6  IR[5:0].
- zero  in  1  ALU zero flag.
- mem_ready  in  1  memory has completed the current read or write this cycle.
- pc_write  out  1  PC register enable.
- iord  out  1  memory address select: 0 = PC, 1 = ALUOut.
- mem_read  out  1  memory read request.
- mem_write  out  1  memory write request.
- ir_write  out  1  IR load enable.
- reg_dst  out  2  write register select: 0 = rt, 1 = rd, 2 = $31.
- mem_to_reg  out  2  write data select: 0 = ALUOut, 1 = MDR, 2 = PC.
- reg_write  out  1  register file write enable.
- alu_src_a  out  1  ALU A select: 0 = PC, 1 = rs.
- alu_src_b  out  2  ALU B select: 0 = rt, 1 = const 4, 2 = sign-extended imm, 3 = sign-extended imm<<2.
- ext_zero  out  1  zero-extend imm instead of sign-extending (ori).
- alu_control  out  3  ALU operation: 000 AND, 001 OR, 010 ADD, 110 SUB, 111 SLT, 100 LUI.
- pc_source  out  2  next-PC select: 0 = ALU, 1 = ALUOut, 2 = jump target, 3 = rs.
- instr_done  out  1  one-cycle pulse on the last cycle of each instruction.
- err  out  1  sticky error flag.
- state  out  4  current state, for debug.

Behaviour:
- Reset:
  - reset low → state = FETCH, wait_cnt = 0, err = 0.
  - While reset is low, all outputs are forced to 0.
  - On release, the first rising edge executes FETCH.
- Outputs are Moore decodes of state, plus opcode/funct in EXEC and zero in BRANCH.
- Any control not listed for a state is 0.
- FETCH:
  - Drives mem_read = 1, iord = 0, alu_src_a = 0, alu_src_b = 1, ADD.
  - When mem_ready = 1: ir_write = 1 and pc_write = 1 (pc_source = 0), then go to DECODE.
  - Otherwise stay in FETCH.
- DECODE:
  - Drives alu_src_a = 0, alu_src_b = 3, ADD, precomputing the branch target into ALUOut.
  - Next state by opcode/funct:
    - lw/sw → MEM_ADDR.
    - R-type (jr excluded) → EXEC_R.
    - ori/lui → EXEC_I.
    - beq → BRANCH.
    - j → JUMP.
    - jal → JAL.
    - jr (R-type, funct 001000) → JR.
    - Full 32-bit-zero nop (opcode 0, funct 0) → FETCH with instr_done = 1.
    - Any other R-funct or opcode → ERR.
- MEM_ADDR: alu_src_a = 1, alu_src_b = 2, ADD. Next is MEM_RD for lw, MEM_WR for sw.
- MEM_RD: mem_read = 1, iord = 1. Waits for mem_ready, then MEM_WB.
- MEM_WB: reg_write = 1, reg_dst = 0, mem_to_reg = 1, instr_done = 1 → FETCH.
- MEM_WR: mem_write = 1, iord = 1. Waits for mem_ready; on that cycle instr_done = 1 → FETCH.
- EXEC_R: alu_src_a = 1, alu_src_b = 0, alu_control from funct: 100001 ADD, 100011 SUB, 100100 AND, 100101 OR, 101010 SLT → R_WB.
- R_WB: reg_write = 1, reg_dst = 1, mem_to_reg = 0, instr_done = 1 → FETCH.
- EXEC_I: alu_src_a = 1, alu_src_b = 2, ext_zero = 1; alu_control is OR for ori, LUI for lui → I_WB.
- I_WB: reg_write = 1, reg_dst = 0, mem_to_reg = 0, instr_done = 1 → FETCH.
- BRANCH: alu_src_a = 1, alu_src_b = 0, SUB, pc_source = 1, pc_write = zero, instr_done = 1 → FETCH.
- JUMP: pc_source = 2, pc_write = 1, instr_done = 1 → FETCH.
- JAL:
  - pc_source = 2, pc_write = 1, reg_write = 1, reg_dst = 2, mem_to_reg = 2, instr_done = 1 → FETCH.
  - The register write samples the PC value before the update, which is already PC+4.
- JR: pc_source = 3, pc_write = 1, instr_done = 1 → FETCH.
- Wait counter:
  - Cleared on entry to FETCH, MEM_RD and MEM_WR.
  - Increments on every cycle in those states with mem_ready = 0.
  - When wait_cnt == WAIT_LIMIT and mem_ready is still 0 → ERR.
  - mem_ready = 1 on the limit cycle wins: the access completes normally.
- ERR:
  - err = 1; all other controls are 0.
  - ERR is absorbing until reset.
  - state output reads 4'hF.
- Reset asserted mid-instruction aborts immediately; partial writes are not replayed.

Decomposition:
- Package mips_ctrl_pkg holds:
  - opcode and funct constants;
  - ALU operation codes;
  - reg_dst, mem_to_reg, alu_src_b and pc_source select codes;
  - the 4-bit state encoding (FETCH = 0 … ERR = F).
- Sub-module mc_alu_decode: purely combinational, (state class, opcode, funct) → alu_control. It is shared with the single-cycle controller.

Test Plan:
- addu, mem_ready always 1 → 4 cycles (FETCH, DECODE, EXEC_R, R_WB), alu_control = 010, reg_write = 1 with reg_dst = 1 in cycle 4, instr_done pulses once.
- lw with mem_ready low for 3 cycles in MEM_RD → MEM_RD lasts 4 cycles, mem_read = 1 and iord = 1 throughout, then MEM_WB with mem_to_reg = 1.
- beq with zero = 1, then with zero = 0 → pc_write = 1 with pc_source = 1 in BRANCH, then pc_write = 0; both take 3 cycles.
- jal → JAL state asserts reg_dst = 2, mem_to_reg = 2, pc_source = 2, pc_write = 1 and reg_write = 1 in the same cycle.
- mem_ready held 0 in FETCH → ERR after WAIT_LIMIT + 1 = 16 cycles; err stays 1 until reset goes low, and err = 0 in the first cycle after release.
- Illegal opcode 6'b111111 in DECODE → ERR. Nop (all-zero IR) → back to FETCH after 2 cycles, reg_write never asserted.

Source files
------------

// File: rtl/mips_ctrl_pkg.sv
// Shared definitions for the MIPS multi-cycle controller: instruction field
// codes, ALU operation codes, datapath select codes and the state encoding.
package mips_ctrl_pkg;

    // Primary opcodes (IR[31:26])
    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_JAL   = 6'b000011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_LUI   = 6'b001111;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;

    // R-type function codes (IR[5:0])
    localparam logic [5:0] FN_NOP   = 6'b000000;
    localparam logic [5:0] FN_JR    = 6'b001000;
    localparam logic [5:0] FN_ADDU  = 6'b100001;
    localparam logic [5:0] FN_SUBU  = 6'b100011;
    localparam logic [5:0] FN_AND   = 6'b100100;
    localparam logic [5:0] FN_OR    = 6'b100101;
    localparam logic [5:0] FN_SLT   = 6'b101010;

    // ALU operations
    localparam logic [2:0] ALU_AND  = 3'b000;
    localparam logic [2:0] ALU_OR   = 3'b001;
    localparam logic [2:0] ALU_ADD  = 3'b010;
    localparam logic [2:0] ALU_LUI  = 3'b100;
    localparam logic [2:0] ALU_SUB  = 3'b110;
    localparam logic [2:0] ALU_SLT  = 3'b111;

    // Write register select
    localparam logic [1:0] REG_DST_RT = 2'd0;
    localparam logic [1:0] REG_DST_RD = 2'd1;
    localparam logic [1:0] REG_DST_RA = 2'd2;

    // Write data select
    localparam logic [1:0] MTR_ALUOUT = 2'd0;
    localparam logic [1:0] MTR_MDR    = 2'd1;
    localparam logic [1:0] MTR_PC     = 2'd2;

    // ALU B select
    localparam logic [1:0] SRCB_RT      = 2'd0;
    localparam logic [1:0] SRCB_FOUR    = 2'd1;
    localparam logic [1:0] SRCB_IMM     = 2'd2;
    localparam logic [1:0] SRCB_IMM_SH2 = 2'd3;

    // Next-PC select
    localparam logic [1:0] PCSRC_ALU    = 2'd0;
    localparam logic [1:0] PCSRC_ALUOUT = 2'd1;
    localparam logic [1:0] PCSRC_JUMP   = 2'd2;
    localparam logic [1:0] PCSRC_RS     = 2'd3;

    typedef enum logic [3:0] {
        S_FETCH    = 4'h0,
        S_DECODE   = 4'h1,
        S_MEM_ADDR = 4'h2,
        S_MEM_RD   = 4'h3,
        S_MEM_WB   = 4'h4,
        S_MEM_WR   = 4'h5,
        S_EXEC_R   = 4'h6,
        S_R_WB     = 4'h7,
        S_EXEC_I   = 4'h8,
        S_I_WB     = 4'h9,
        S_BRANCH   = 4'hA,
        S_JUMP     = 4'hB,
        S_JAL      = 4'hC,
        S_JR       = 4'hD,
        S_ERR      = 4'hF
    } state_e;

    // What the ALU is being used for in the current state; the ALU decoder
    // turns this plus the instruction fields into an operation code.
    typedef enum logic [2:0] {
        CLS_NONE  = 3'd0,
        CLS_ADD   = 3'd1,
        CLS_SUB   = 3'd2,
        CLS_FUNCT = 3'd3,
        CLS_IMM   = 3'd4
    } alu_class_e;

    // States that stall on the memory handshake and are covered by the
    // wait counter.
    function automatic logic is_wait_state(input state_e s);
        return (s == S_FETCH) || (s == S_MEM_RD) || (s == S_MEM_WR);
    endfunction

endpackage

// File: rtl/multicycle_ctrl_if.sv
// Controller <-> datapath/memory bundle.
//   master : the controller (drives controls, receives IR fields/flags)
//   slave  : the datapath side
interface multicycle_ctrl_if;
    logic [5:0] opcode;
    logic [5:0] funct;
    logic       zero;
    logic       mem_ready;

    logic       pc_write;
    logic       iord;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic [1:0] reg_dst;
    logic [1:0] mem_to_reg;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic       ext_zero;
    logic [2:0] alu_control;
    logic [1:0] pc_source;
    logic       instr_done;
    logic       err;
    logic [3:0] state;

    modport master (
        input  opcode, funct, zero, mem_ready,
        output pc_write, iord, mem_read, mem_write, ir_write, reg_dst,
               mem_to_reg, reg_write, alu_src_a, alu_src_b, ext_zero,
               alu_control, pc_source, instr_done, err, state
    );

    modport slave (
        output opcode, funct, zero, mem_ready,
        input  pc_write, iord, mem_read, mem_write, ir_write, reg_dst,
               mem_to_reg, reg_write, alu_src_a, alu_src_b, ext_zero,
               alu_control, pc_source, instr_done, err, state
    );
endinterface

// File: rtl/mc_alu_decode.sv
// Combinational ALU operation decoder, shared with the single-cycle core.
//   cls_i         : how the ALU is used this cycle
//   opcode_i      : IR[31:26]
//   funct_i       : IR[5:0]
//   alu_control_o : ALU operation code
module mc_alu_decode
    import mips_ctrl_pkg::*;
(
    input  alu_class_e cls_i,
    input  logic [5:0] opcode_i,
    input  logic [5:0] funct_i,
    output logic [2:0] alu_control_o
);

    always_comb begin
        alu_control_o = ALU_AND;
        case (cls_i)
            CLS_ADD: alu_control_o = ALU_ADD;
            CLS_SUB: alu_control_o = ALU_SUB;
            CLS_FUNCT: begin
                case (funct_i)
                    FN_ADDU: alu_control_o = ALU_ADD;
                    FN_SUBU: alu_control_o = ALU_SUB;
                    FN_AND:  alu_control_o = ALU_AND;
                    FN_OR:   alu_control_o = ALU_OR;
                    FN_SLT:  alu_control_o = ALU_SLT;
                    default: alu_control_o = ALU_ADD;
                endcase
            end
            CLS_IMM: alu_control_o = (opcode_i == OP_LUI) ? ALU_LUI : ALU_OR;
            default: alu_control_o = ALU_AND;
        endcase
    end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multi-cycle MIPS control sequencer (Moore FSM) with bounded memory waits.
//   clk   : system clock, rising edge
//   reset : asynchronous active-low reset; all controls read 0 while low
//   ctrl  : master side of multicycle_ctrl_if (IR fields, flags, controls)
// WAIT_W must satisfy 2**WAIT_W > WAIT_LIMIT.
//
// state    | meaning
// ---------+------------------------------------------------------
// FETCH    | read IR from mem[PC], PC <= PC+4 when mem_ready
// DECODE   | branch target into ALUOut, dispatch on opcode/funct
// MEM_ADDR | effective address for lw/sw
// MEM_RD   | load access, wait for mem_ready
// MEM_WB   | MDR -> rt
// MEM_WR   | store access, wait for mem_ready
// EXEC_R   | R-type ALU operation
// R_WB     | ALUOut -> rd
// EXEC_I   | ori/lui ALU operation (zero-extended imm)
// I_WB     | ALUOut -> rt
// BRANCH   | beq compare, PC <= ALUOut if equal
// JUMP     | PC <= jump target
// JAL      | $31 <= PC, PC <= jump target
// JR       | PC <= rs
// ERR      | sticky: memory timeout or illegal instruction
module multicycle_ctrl
    import mips_ctrl_pkg::*;
#(
    parameter int WAIT_LIMIT = 15,
    parameter int WAIT_W     = 4
) (
    input  logic              clk,
    input  logic              reset,
    multicycle_ctrl_if.master ctrl
);

    localparam logic [WAIT_W-1:0] WAIT_LIMIT_C = WAIT_LIMIT[WAIT_W-1:0];

    state_e            state_q, state_d;
    logic [WAIT_W-1:0] wait_q, wait_d;

    alu_class_e alu_cls;
    logic [2:0] alu_ctrl;

    logic       pc_write_c, iord_c, mem_read_c, mem_write_c, ir_write_c;
    logic [1:0] reg_dst_c, mem_to_reg_c, alu_src_b_c, pc_source_c;
    logic       reg_write_c, alu_src_a_c, ext_zero_c, instr_done_c, err_c;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_FETCH;
            wait_q  <= '0;
        end else begin
            state_q <= state_d;
            wait_q  <= wait_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        wait_d       = wait_q;
        alu_cls      = CLS_NONE;
        pc_write_c   = 1'b0;
        iord_c       = 1'b0;
        mem_read_c   = 1'b0;
        mem_write_c  = 1'b0;
        ir_write_c   = 1'b0;
        reg_dst_c    = REG_DST_RT;
        mem_to_reg_c = MTR_ALUOUT;
        reg_write_c  = 1'b0;
        alu_src_a_c  = 1'b0;
        alu_src_b_c  = SRCB_RT;
        ext_zero_c   = 1'b0;
        pc_source_c  = PCSRC_ALU;
        instr_done_c = 1'b0;
        err_c        = 1'b0;

        case (state_q)
            S_FETCH: begin
                mem_read_c  = 1'b1;
                alu_src_b_c = SRCB_FOUR;
                alu_cls     = CLS_ADD;
                if (ctrl.mem_ready) begin
                    ir_write_c = 1'b1;
                    pc_write_c = 1'b1;
                    state_d    = S_DECODE;
                end else if (wait_q >= WAIT_LIMIT_C) begin
                    state_d = S_ERR;
                end
            end
            S_DECODE: begin
                alu_src_b_c = SRCB_IMM_SH2;
                alu_cls     = CLS_ADD;
                case (ctrl.opcode)
                    OP_RTYPE: begin
                        case (ctrl.funct)
                            FN_JR: state_d = S_JR;
                            FN_NOP: begin
                                state_d      = S_FETCH;
                                instr_done_c = 1'b1;
                            end
                            FN_ADDU, FN_SUBU, FN_AND, FN_OR, FN_SLT:
                                state_d = S_EXEC_R;
                            default: state_d = S_ERR;
                        endcase
                    end
                    OP_LW, OP_SW:   state_d = S_MEM_ADDR;
                    OP_ORI, OP_LUI: state_d = S_EXEC_I;
                    OP_BEQ:         state_d = S_BRANCH;
                    OP_J:           state_d = S_JUMP;
                    OP_JAL:         state_d = S_JAL;
                    default:        state_d = S_ERR;
                endcase
            end
            S_MEM_ADDR: begin
                alu_src_a_c = 1'b1;
                alu_src_b_c = SRCB_IMM;
                alu_cls     = CLS_ADD;
                if (ctrl.opcode == OP_LW)      state_d = S_MEM_RD;
                else if (ctrl.opcode == OP_SW) state_d = S_MEM_WR;
                else                           state_d = S_ERR;
            end
            S_MEM_RD: begin
                mem_read_c = 1'b1;
                iord_c     = 1'b1;
                if (ctrl.mem_ready)              state_d = S_MEM_WB;
                else if (wait_q >= WAIT_LIMIT_C) state_d = S_ERR;
            end
            S_MEM_WB: begin
                reg_write_c  = 1'b1;
                reg_dst_c    = REG_DST_RT;
                mem_to_reg_c = MTR_MDR;
                instr_done_c = 1'b1;
                state_d      = S_FETCH;
            end
            S_MEM_WR: begin
                mem_write_c = 1'b1;
                iord_c      = 1'b1;
                if (ctrl.mem_ready) begin
                    instr_done_c = 1'b1;
                    state_d      = S_FETCH;
                end else if (wait_q >= WAIT_LIMIT_C) begin
                    state_d = S_ERR;
                end
            end
            S_EXEC_R: begin
                alu_src_a_c = 1'b1;
                alu_src_b_c = SRCB_RT;
                alu_cls     = CLS_FUNCT;
                state_d     = S_R_WB;
            end
            S_R_WB: begin
                reg_write_c  = 1'b1;
                reg_dst_c    = REG_DST_RD;
                mem_to_reg_c = MTR_ALUOUT;
                instr_done_c = 1'b1;
                state_d      = S_FETCH;
            end
            S_EXEC_I: begin
                alu_src_a_c = 1'b1;
                alu_src_b_c = SRCB_IMM;
                ext_zero_c  = 1'b1;
                alu_cls     = CLS_IMM;
                state_d     = S_I_WB;
            end
            S_I_WB: begin
                reg_write_c  = 1'b1;
                reg_dst_c    = REG_DST_RT;
                mem_to_reg_c = MTR_ALUOUT;
                instr_done_c = 1'b1;
                state_d      = S_FETCH;
            end
            S_BRANCH: begin
                alu_src_a_c  = 1'b1;
                alu_src_b_c  = SRCB_RT;
                alu_cls      = CLS_SUB;
                pc_source_c  = PCSRC_ALUOUT;
                pc_write_c   = ctrl.zero;
                instr_done_c = 1'b1;
                state_d      = S_FETCH;
            end
            S_JUMP: begin
                pc_source_c  = PCSRC_JUMP;
                pc_write_c   = 1'b1;
                instr_done_c = 1'b1;
                state_d      = S_FETCH;
            end
            S_JAL: begin
                // PC already holds PC+4 from FETCH, which is the link value.
                pc_source_c  = PCSRC_JUMP;
                pc_write_c   = 1'b1;
                reg_write_c  = 1'b1;
                reg_dst_c    = REG_DST_RA;
                mem_to_reg_c = MTR_PC;
                instr_done_c = 1'b1;
                state_d      = S_FETCH;
            end
            S_JR: begin
                pc_source_c  = PCSRC_RS;
                pc_write_c   = 1'b1;
                instr_done_c = 1'b1;
                state_d      = S_FETCH;
            end
            S_ERR: begin
                err_c = 1'b1;
            end
            default: begin
                state_d = S_ERR;
            end
        endcase

        // Any state change restarts the count, so every stalling state
        // starts from zero on entry; mem_ready on the limit cycle still
        // completes the access because it is checked first above.
        if (state_d != state_q) begin
            wait_d = '0;
        end else if (is_wait_state(state_q) && !ctrl.mem_ready) begin
            wait_d = wait_q + 1'b1;
        end
    end

    mc_alu_decode u_alu_decode (
        .cls_i         (alu_cls),
        .opcode_i      (ctrl.opcode),
        .funct_i       (ctrl.funct),
        .alu_control_o (alu_ctrl)
    );

    // Controls are masked while reset is held so that FETCH does not issue
    // a memory read before the block is released.
    assign ctrl.pc_write    = reset & pc_write_c;
    assign ctrl.iord        = reset & iord_c;
    assign ctrl.mem_read    = reset & mem_read_c;
    assign ctrl.mem_write   = reset & mem_write_c;
    assign ctrl.ir_write    = reset & ir_write_c;
    assign ctrl.reg_dst     = reset ? reg_dst_c    : 2'b00;
    assign ctrl.mem_to_reg  = reset ? mem_to_reg_c : 2'b00;
    assign ctrl.reg_write   = reset & reg_write_c;
    assign ctrl.alu_src_a   = reset & alu_src_a_c;
    assign ctrl.alu_src_b   = reset ? alu_src_b_c  : 2'b00;
    assign ctrl.ext_zero    = reset & ext_zero_c;
    assign ctrl.alu_control = reset ? alu_ctrl     : 3'b000;
    assign ctrl.pc_source   = reset ? pc_source_c  : 2'b00;
    assign ctrl.instr_done  = reset & instr_done_c;
    assign ctrl.err         = reset & err_c;
    assign ctrl.state       = reset ? state_q      : 4'h0;

endmodule

// File: tb/tb_multicycle_ctrl.sv
module tb_multicycle_ctrl;

    typedef struct packed {
        logic       pc_write;
        logic       iord;
        logic       mem_read;
        logic       mem_write;
        logic       ir_write;
        logic [1:0] reg_dst;
        logic [1:0] mem_to_reg;
        logic       reg_write;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic       ext_zero;
        logic [2:0] alu_control;
        logic [1:0] pc_source;
        logic       instr_done;
        logic       err;
        logic [3:0] state;
    } out_t;

    typedef struct {
        string tag;
        out_t  v;
    } exp_rec_t;

    logic clk;
    logic reset;
    int   checks;
    int   errors;
    exp_rec_t q[$];

    multicycle_ctrl_if bus();

    multicycle_ctrl #(.WAIT_LIMIT(15), .WAIT_W(4)) dut (
        .clk   (clk),
        .reset (reset),
        .ctrl  (bus.master)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Monitor: every cycle that has an expectation queued is compared.
    always @(negedge clk) begin
        exp_rec_t e;
        out_t     got;
        if (q.size() > 0) begin
            e = q.pop_front();
            got = '{pc_write: bus.pc_write, iord: bus.iord, mem_read: bus.mem_read,
                    mem_write: bus.mem_write, ir_write: bus.ir_write,
                    reg_dst: bus.reg_dst, mem_to_reg: bus.mem_to_reg,
                    reg_write: bus.reg_write, alu_src_a: bus.alu_src_a,
                    alu_src_b: bus.alu_src_b, ext_zero: bus.ext_zero,
                    alu_control: bus.alu_control, pc_source: bus.pc_source,
                    instr_done: bus.instr_done, err: bus.err, state: bus.state};
            checks++;
            if (got !== e.v) begin
                errors++;
                $display("FAIL %s: got=%07h exp=%07h (state got %h exp %h)",
                         e.tag, got, e.v, got.state, e.v.state);
            end
        end
    end

    // Hand-written expected control words, one per FSM state.
    function automatic out_t z();
        return '0;
    endfunction
    function automatic out_t x_fetch(input logic rdy);
        out_t o = '0;
        o.mem_read = 1; o.alu_src_b = 2'd1; o.alu_control = 3'b010;
        o.ir_write = rdy; o.pc_write = rdy; o.state = 4'h0;
        return o;
    endfunction
    function automatic out_t x_decode(input logic done);
        out_t o = '0;
        o.alu_src_b = 2'd3; o.alu_control = 3'b010; o.instr_done = done; o.state = 4'h1;
        return o;
    endfunction
    function automatic out_t x_memaddr();
        out_t o = '0;
        o.alu_src_a = 1; o.alu_src_b = 2'd2; o.alu_control = 3'b010; o.state = 4'h2;
        return o;
    endfunction
    function automatic out_t x_memrd();
        out_t o = '0;
        o.mem_read = 1; o.iord = 1; o.state = 4'h3;
        return o;
    endfunction
    function automatic out_t x_memwb();
        out_t o = '0;
        o.reg_write = 1; o.mem_to_reg = 2'd1; o.instr_done = 1; o.state = 4'h4;
        return o;
    endfunction
    function automatic out_t x_memwr(input logic rdy);
        out_t o = '0;
        o.mem_write = 1; o.iord = 1; o.instr_done = rdy; o.state = 4'h5;
        return o;
    endfunction
    function automatic out_t x_execr(input logic [2:0] alu);
        out_t o = '0;
        o.alu_src_a = 1; o.alu_control = alu; o.state = 4'h6;
        return o;
    endfunction
    function automatic out_t x_rwb();
        out_t o = '0;
        o.reg_write = 1; o.reg_dst = 2'd1; o.instr_done = 1; o.state = 4'h7;
        return o;
    endfunction
    function automatic out_t x_execi(input logic [2:0] alu);
        out_t o = '0;
        o.alu_src_a = 1; o.alu_src_b = 2'd2; o.ext_zero = 1; o.alu_control = alu; o.state = 4'h8;
        return o;
    endfunction
    function automatic out_t x_iwb();
        out_t o = '0;
        o.reg_write = 1; o.instr_done = 1; o.state = 4'h9;
        return o;
    endfunction
    function automatic out_t x_branch(input logic zf);
        out_t o = '0;
        o.alu_src_a = 1; o.alu_control = 3'b110; o.pc_source = 2'd1;
        o.pc_write = zf; o.instr_done = 1; o.state = 4'hA;
        return o;
    endfunction
    function automatic out_t x_jump();
        out_t o = '0;
        o.pc_source = 2'd2; o.pc_write = 1; o.instr_done = 1; o.state = 4'hB;
        return o;
    endfunction
    function automatic out_t x_jal();
        out_t o = '0;
        o.pc_source = 2'd2; o.pc_write = 1; o.reg_write = 1; o.reg_dst = 2'd2;
        o.mem_to_reg = 2'd2; o.instr_done = 1; o.state = 4'hC;
        return o;
    endfunction
    function automatic out_t x_jr();
        out_t o = '0;
        o.pc_source = 2'd3; o.pc_write = 1; o.instr_done = 1; o.state = 4'hD;
        return o;
    endfunction
    function automatic out_t x_err();
        out_t o = '0;
        o.err = 1; o.state = 4'hF;
        return o;
    endfunction

    // Drive this cycle's inputs, queue the expected outputs, advance a cycle.
    task automatic step(input string tag, input logic rdy, input logic zf, input out_t v);
        exp_rec_t e;
        bus.mem_ready = rdy;
        bus.zero      = zf;
        e.tag = tag;
        e.v   = v;
        q.push_back(e);
        @(posedge clk);
        #1;
    endtask

    task automatic set_ir(input logic [5:0] op, input logic [5:0] fn);
        bus.opcode = op;
        bus.funct  = fn;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [5:0] fn_tab  [5];
        logic [2:0] alu_tab [5];
        fn_tab  = '{6'b100001, 6'b100011, 6'b100100, 6'b100101, 6'b101010};
        alu_tab = '{3'b010,    3'b110,    3'b000,    3'b001,    3'b111};

        checks = 0;
        errors = 0;
        reset  = 1'b0;
        bus.opcode = 6'h00; bus.funct = 6'h00; bus.zero = 1'b0; bus.mem_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;

        // Outputs held at zero during reset even though FETCH would read.
        step("reset0", 1, 0, z());
        step("reset1", 1, 0, z());
        reset = 1'b1;

        // addu then the other R-types
        set_ir(6'b000000, 6'b100001);
        step("addu_fetch", 1, 0, x_fetch(1));
        step("addu_decode", 1, 0, x_decode(0));
        step("addu_exec", 1, 0, x_execr(3'b010));
        step("addu_wb", 1, 0, x_rwb());
        for (int i = 0; i < 5; i++) begin
            set_ir(6'b000000, fn_tab[i]);
            step($sformatf("r%0d_fetch", i), 1, 0, x_fetch(1));
            step($sformatf("r%0d_decode", i), 1, 0, x_decode(0));
            step($sformatf("r%0d_exec", i), 1, 0, x_execr(alu_tab[i]));
            step($sformatf("r%0d_wb", i), 1, 0, x_rwb());
        end

        // lw: fetch completes exactly on the limit cycle, then 3 read stalls
        set_ir(6'b100011, 6'b000000);
        for (int i = 0; i < 15; i++) step("lw_fetch_wait", 0, 0, x_fetch(0));
        step("lw_fetch_limit", 1, 0, x_fetch(1));
        step("lw_decode", 1, 0, x_decode(0));
        step("lw_addr", 1, 0, x_memaddr());
        for (int i = 0; i < 3; i++) step("lw_rd_wait", 0, 0, x_memrd());
        step("lw_rd_done", 1, 0, x_memrd());
        step("lw_wb", 1, 0, x_memwb());

        // sw with two write stalls
        set_ir(6'b101011, 6'b000000);
        step("sw_fetch", 1, 0, x_fetch(1));
        step("sw_decode", 1, 0, x_decode(0));
        step("sw_addr", 1, 0, x_memaddr());
        step("sw_wr_wait", 0, 0, x_memwr(0));
        step("sw_wr_wait", 0, 0, x_memwr(0));
        step("sw_wr_done", 1, 0, x_memwr(1));

        // ori / lui
        set_ir(6'b001101, 6'b010101);
        step("ori_fetch", 1, 0, x_fetch(1));
        step("ori_decode", 1, 0, x_decode(0));
        step("ori_exec", 1, 0, x_execi(3'b001));
        step("ori_wb", 1, 0, x_iwb());
        set_ir(6'b001111, 6'b100001);
        step("lui_fetch", 1, 0, x_fetch(1));
        step("lui_decode", 1, 0, x_decode(0));
        step("lui_exec", 1, 0, x_execi(3'b100));
        step("lui_wb", 1, 0, x_iwb());

        // beq taken then not taken
        set_ir(6'b000100, 6'b000000);
        step("beq1_fetch", 1, 0, x_fetch(1));
        step("beq1_decode", 1, 0, x_decode(0));
        step("beq1_branch", 1, 1, x_branch(1));
        step("beq0_fetch", 1, 0, x_fetch(1));
        step("beq0_decode", 1, 0, x_decode(0));
        step("beq0_branch", 1, 0, x_branch(0));

        // j, jal, jr
        set_ir(6'b000010, 6'b000000);
        step("j_fetch", 1, 0, x_fetch(1));
        step("j_decode", 1, 0, x_decode(0));
        step("j_jump", 1, 0, x_jump());
        set_ir(6'b000011, 6'b000000);
        step("jal_fetch", 1, 0, x_fetch(1));
        step("jal_decode", 1, 0, x_decode(0));
        step("jal_jal", 1, 0, x_jal());
        set_ir(6'b000000, 6'b001000);
        step("jr_fetch", 1, 0, x_fetch(1));
        step("jr_decode", 1, 0, x_decode(0));
        step("jr_jr", 1, 0, x_jr());

        // nop: two cycles, no register write
        set_ir(6'b000000, 6'b000000);
        step("nop_fetch", 1, 0, x_fetch(1));
        step("nop_decode", 1, 0, x_decode(1));

        // illegal opcode -> ERR, absorbing
        set_ir(6'b111111, 6'b000000);
        step("ill_fetch", 1, 0, x_fetch(1));
        step("ill_decode", 1, 0, x_decode(0));
        step("ill_err0", 1, 1, x_err());
        step("ill_err1", 0, 0, x_err());
        reset = 1'b0;
        step("ill_reset", 1, 0, z());
        reset = 1'b1;

        // illegal R funct -> ERR
        set_ir(6'b000000, 6'b111111);
        step("illfn_fetch", 1, 0, x_fetch(1));
        step("illfn_decode", 1, 0, x_decode(0));
        step("illfn_err", 1, 0, x_err());
        reset = 1'b0;
        step("illfn_reset", 1, 0, z());
        reset = 1'b1;

        // fetch timeout: 16 stalled cycles, then sticky ERR until reset
        set_ir(6'b000000, 6'b100001);
        for (int i = 0; i < 16; i++) step("to_fetch_wait", 0, 0, x_fetch(0));
        step("to_err0", 0, 0, x_err());
        step("to_err1", 1, 0, x_err());
        step("to_err2", 1, 0, x_err());
        reset = 1'b0;
        step("to_reset", 1, 0, z());
        reset = 1'b1;
        step("to_rel_fetch", 1, 0, x_fetch(1));
        step("to_rel_decode", 1, 0, x_decode(0));
        step("to_rel_exec", 1, 0, x_execr(3'b010));
        step("to_rel_wb", 1, 0, x_rwb());

        @(negedge clk);
        #1;
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL queue_drain: got %0d left exp 0", q.size());
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
